watch_time_ctrl: RTL and testbench

//  Sequencer for the watch time counters (seconds, minutes, hours).

---
 rtl/watch_pkg.sv | 15 +
 rtl/watch_time_ctrl_if.sv | 28 ++
 rtl/btn_edge.sv | 23 ++
 rtl/watch_time_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_watch_time_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: shared mode encodings and helpers for the watch time sequencer.
package watch_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL   = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_t;

   // True for either of the two user set modes
   function automatic logic isSetMode(input mode_t m);
      return (m == MODE_SET_HOUR) || (m == MODE_SET_MIN);
   endfunction

endpackage

// File: rtl/watch_time_ctrl_if.sv
// watch_time_ctrl_if: button/wrap inputs and counter-control outputs of the
// watch time sequencer. The controller uses the master modport; the
// environment that owns the buttons and counters uses the slave modport.
interface watch_time_ctrl_if;
   import watch_pkg::*;

   logic  mode_btn;
   logic  inc_btn;
   logic  sec_wrap;
   logic  min_wrap;
   logic  sec_inc;
   logic  min_inc;
   logic  hour_inc;
   logic  sec_clr;
   mode_t mode;
   logic  blink;

   modport master (
      input  mode_btn, inc_btn, sec_wrap, min_wrap,
      output sec_inc, min_inc, hour_inc, sec_clr, mode, blink
   );

   modport slave (
      output mode_btn, inc_btn, sec_wrap, min_wrap,
      input  sec_inc, min_inc, hour_inc, sec_clr, mode, blink
   );

endinterface

// File: rtl/btn_edge.sv
// btn_edge: one-flop history of a debounced button plus a rising-edge pulse.
// The history resets to 1 so a button held through reset is not a press.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic rise_o
);

   logic hist_q;

   // Remember last cycle's button level
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 1'b1;
      end else begin
         hist_q <= btn_i;
      end
   end

   assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl: 1 Hz prescaler, cascaded increment pulses for the
// sec/min/hour counters, and the NORMAL -> SET_HOUR -> SET_MIN user FSM.
// Optional feature macro: WATCH_AUTO_REPEAT_EN (hold-to-repeat on inc_btn).
module watch_time_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned BLINK_DIV  = 25_000_000
`ifdef WATCH_AUTO_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DLY = 25_000_000,
   parameter int unsigned REPEAT_PER = 10_000_000
`endif
) (
   input  logic              clk,
   input  logic              rst,
   watch_time_ctrl_if.master bus
);

   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam int unsigned BLK_W = $clog2(BLINK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic             modeRise;
   logic             incRise;
   logic             tick;
   logic             incStep;
   logic             modeChange;
   logic             exitSetMin;
   mode_t            mode_q;
   mode_t            mode_d;
   logic [PRE_W-1:0] preCnt_q;
   logic [BLK_W-1:0] blinkCnt_q;
   logic             blink_q;
   logic             secInc_q;
   logic             secInc_d;
   logic             minInc_q;
   logic             minInc_d;
   logic             hourInc_q;
   logic             hourInc_d;
   logic             secClr_q;
   logic             secClr_d;

   btn_edge uModeEdge (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.mode_btn),
      .rise_o (modeRise)
   );

   btn_edge uIncEdge (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.inc_btn),
      .rise_o (incRise)
   );

   assign tick = (preCnt_q == PRE_LAST);

`ifdef WATCH_AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int unsigned REP_W   = $clog2(REP_MAX);
   localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DLY - 1);
   localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PER - 1);

   logic             repArmed_q;
   logic             repFirst_q;
   logic [REP_W-1:0] repCnt_q;
   logic             repeatFire;

   assign repeatFire = repArmed_q & bus.inc_btn & isSetMode(mode_q) &
                       (repFirst_q ? (repCnt_q == DLY_LAST) : (repCnt_q == PER_LAST));

   // Hold timer: arms on a press in a set mode, first repeat after the
   // initial delay, then at the repeat period; release or mode change disarms
   always_ff @(posedge clk) begin
      if (rst) begin
         repArmed_q <= 1'b0;
         repFirst_q <= 1'b1;
         repCnt_q   <= '0;
      end else if (modeChange || !bus.inc_btn || !isSetMode(mode_q)) begin
         repArmed_q <= 1'b0;
         repFirst_q <= 1'b1;
         repCnt_q   <= '0;
      end else if (incRise && !modeRise) begin
         repArmed_q <= 1'b1;
         repFirst_q <= 1'b1;
         repCnt_q   <= '0;
      end else if (repeatFire) begin
         repFirst_q <= 1'b0;
         repCnt_q   <= '0;
      end else if (repArmed_q) begin
         repCnt_q   <= repCnt_q + REP_W'(1);
      end
   end

   assign incStep = (incRise | repeatFire) & ~modeRise;
`else
   assign incStep = incRise & ~modeRise;
`endif

   // Mode FSM next state plus the next values of every registered pulse;
   // a mode edge swallows any inc step or tick arriving in the same cycle
   always_comb begin
      mode_d     = mode_q;
      exitSetMin = 1'b0;
      secInc_d   = 1'b0;
      minInc_d   = 1'b0;
      hourInc_d  = 1'b0;
      case (mode_q)
         MODE_NORMAL: begin
            if (modeRise) begin
               mode_d = MODE_SET_HOUR;
            end else if (tick) begin
               secInc_d  = 1'b1;
               minInc_d  = bus.sec_wrap;
               hourInc_d = bus.sec_wrap & bus.min_wrap;
            end
         end
         MODE_SET_HOUR: begin
            if (modeRise) begin
               mode_d = MODE_SET_MIN;
            end
            hourInc_d = incStep;
         end
         MODE_SET_MIN: begin
            if (modeRise) begin
               mode_d     = MODE_NORMAL;
               exitSetMin = 1'b1;
            end
            minInc_d = incStep;
         end
         default: begin
            mode_d = MODE_NORMAL;
         end
      endcase
      modeChange = (mode_d != mode_q);
      secClr_d   = exitSetMin;
   end

   // Mode register and the one-cycle output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= MODE_NORMAL;
         secInc_q  <= 1'b0;
         minInc_q  <= 1'b0;
         hourInc_q <= 1'b0;
         secClr_q  <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         secInc_q  <= secInc_d;
         minInc_q  <= minInc_d;
         hourInc_q <= hourInc_d;
         secClr_q  <= secClr_d;
      end
   end

   // 1 Hz prescaler; restarts from zero on return to NORMAL so the first
   // second after setting the time is a full one
   always_ff @(posedge clk) begin
      if (rst) begin
         preCnt_q <= '0;
      end else if (exitSetMin || tick) begin
         preCnt_q <= '0;
      end else begin
         preCnt_q <= preCnt_q + PRE_W'(1);
      end
   end

   // Blink phase: starts lit on entering a set mode, toggles every
   // BLINK_DIV cycles, and is held dark in NORMAL
   always_ff @(posedge clk) begin
      if (rst) begin
         blinkCnt_q <= '0;
         blink_q    <= 1'b0;
      end else if (modeChange) begin
         blinkCnt_q <= '0;
         blink_q    <= isSetMode(mode_d);
      end else if (!isSetMode(mode_q)) begin
         blinkCnt_q <= '0;
         blink_q    <= 1'b0;
      end else if (blinkCnt_q == BLK_LAST) begin
         blinkCnt_q <= '0;
         blink_q    <= ~blink_q;
      end else begin
         blinkCnt_q <= blinkCnt_q + BLK_W'(1);
      end
   end

   assign bus.sec_inc  = secInc_q;
   assign bus.min_inc  = minInc_q;
   assign bus.hour_inc = hourInc_q;
   assign bus.sec_clr  = secClr_q;
   assign bus.mode     = mode_q;
   assign bus.blink    = blink_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// tb_watch_time_ctrl: table-driven vectors, hand-written corner sequences and
// randomized stimulus against a cycle-level behavioural model.
module tb_watch_time_ctrl;
   import watch_pkg::*;

   localparam int TICK_DIV   = 4;
   localparam int BLINK_DIV  = 3;
   localparam int REPEAT_DLY = 8;
   localparam int REPEAT_PER = 4;
`ifdef WATCH_AUTO_REPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   watch_time_ctrl_if bus ();

   watch_time_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .BLINK_DIV  (BLINK_DIV)
`ifdef WATCH_AUTO_REPEAT_EN
      ,
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   typedef struct {
      bit         mb;
      bit         ib;
      bit         sw;
      bit         mw;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[$];

   int         mMode;
   int         mSince;
   int         mBlinkAge;
   int         mHoldAge;
   bit         mPrevMode;
   bit         mPrevInc;
   bit         mHeld;
   logic [6:0] expVec;

   function automatic vec_t mk(input bit mb, input bit ib, input bit sw, input bit mw,
                               input bit s, input bit m, input bit h, input bit c,
                               input logic [1:0] md, input bit bl);
      vec_t v;
      v.mb  = mb;
      v.ib  = ib;
      v.sw  = sw;
      v.mw  = mw;
      v.exp = {s, m, h, c, md, bl};
      return v;
   endfunction

   function automatic logic [6:0] dutVec();
      return {bus.sec_inc, bus.min_inc, bus.hour_inc, bus.sec_clr, bus.mode, bus.blink};
   endfunction

   task automatic modelStep(input bit r, input bit mb, input bit ib, input bit sw, input bit mw);
      bit mRise;
      bit iRise;
      bit tick;
      bit step;
      bit eSec;
      bit eMin;
      bit eHour;
      bit eClr;
      bit eBlink;
      int nextMode;
      if (r) begin
         mMode     = 0;
         mSince    = 0;
         mBlinkAge = 0;
         mHoldAge  = 0;
         mHeld     = 1'b0;
         mPrevMode = 1'b1;
         mPrevInc  = 1'b1;
         expVec    = '0;
         return;
      end
      mRise    = mb && !mPrevMode;
      iRise    = ib && !mPrevInc;
      tick     = (mSince % TICK_DIV) == TICK_DIV - 1;
      nextMode = mRise ? (mMode + 1) % 3 : mMode;
      step     = iRise && !mRise;
      if (mMode != 0 && iRise && !mRise) begin
         mHeld    = 1'b1;
         mHoldAge = 0;
      end else if (mHeld && ib && !mRise && mMode != 0) begin
         mHoldAge++;
         if (REPEAT_ON && (mHoldAge == REPEAT_DLY ||
             (mHoldAge > REPEAT_DLY && (mHoldAge - REPEAT_DLY) % REPEAT_PER == 0)))
            step = 1'b1;
      end else begin
         mHeld = 1'b0;
      end
      eSec  = (mMode == 0) && tick && !mRise;
      eMin  = (eSec && sw) || (mMode == 2 && step);
      eHour = (eSec && sw && mw) || (mMode == 1 && step);
      eClr  = (mMode == 2) && mRise;
      if (eClr) mSince = 0;
      else      mSince++;
      if (nextMode != mMode) mBlinkAge = 0;
      else                   mBlinkAge++;
      eBlink    = (nextMode != 0) && (((mBlinkAge / BLINK_DIV) % 2) == 0);
      mMode     = nextMode;
      mPrevMode = mb;
      mPrevInc  = ib;
      expVec    = {eSec, eMin, eHour, eClr, 2'(nextMode), eBlink};
   endtask

   task automatic checkOutput(input string name, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got {sec,min,hour,clr,mode,blink}=%b want %b at %0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit mb, input bit ib, input bit sw, input bit mw);
      rst          = r;
      bus.mode_btn = mb;
      bus.inc_btn  = ib;
      bus.sec_wrap = sw;
      bus.min_wrap = mw;
      modelStep(r, mb, ib, sw, mw);
      @(posedge clk);
      #1;
      checkOutput("model", dutVec(), expVec);
   endtask

   initial begin
      int offs[$];
      int expOffs[$];
      bit mb;
      bit ib;

      // mb ib sw mw | sec min hour clr mode blink
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 1,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 1,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,1, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,1, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,1, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,1, 1,1,1,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,1,0, 1,1,0,0, 2'd0,0));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd1,1));
      tbl.push_back(mk(1,1,0,0, 0,0,1,0, 2'd1,1));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd1,1));
      tbl.push_back(mk(1,1,0,0, 0,0,1,0, 2'd1,0));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd1,0));
      tbl.push_back(mk(1,1,0,0, 0,0,1,0, 2'd1,0));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd1,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd1,1));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd2,1));
      tbl.push_back(mk(1,1,0,0, 0,1,0,0, 2'd2,1));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd2,1));
      tbl.push_back(mk(1,1,1,1, 0,1,0,0, 2'd2,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd2,0));
      tbl.push_back(mk(1,0,0,0, 0,0,0,1, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 1,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd0,0));
      tbl.push_back(mk(1,1,0,0, 0,0,0,0, 2'd1,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd1,1));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 2'd2,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2'd2,1));
      tbl.push_back(mk(1,0,0,0, 0,0,0,1, 2'd0,0));

      $display("[TB] reset");
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("resetState", dutVec(), 7'b0);

      $display("[TB] table vectors");
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(0, tbl[i].mb, tbl[i].ib, tbl[i].sw, tbl[i].mw);
         checkOutput($sformatf("table%0d", i + 1), dutVec(), tbl[i].exp);
      end

      $display("[TB] inc held in SET_HOUR");
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      for (int j = 0; j < 20; j++) begin
         applyStimulus(0, 0, 1, 0, 0);
         if (bus.hour_inc) offs.push_back(j + 1);
      end
      applyStimulus(0, 0, 0, 0, 0);
      expOffs.push_back(1);
      if (REPEAT_ON) begin
         expOffs.push_back(9);
         expOffs.push_back(13);
         expOffs.push_back(17);
      end
      checks++;
      if (offs.size() != expOffs.size()) begin
         errors++;
         $display("[TB] FAIL repeatCount got %0d want %0d", offs.size(), expOffs.size());
      end
      for (int k = 0; k < offs.size() && k < expOffs.size(); k++) begin
         checks++;
         if (offs[k] != expOffs[k]) begin
            errors++;
            $display("[TB] FAIL repeatOffset%0d got +%0d want +%0d", k, offs[k], expOffs[k]);
         end
      end

      $display("[TB] reset with pending press, buttons held through reset");
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("resetDropsPulse", dutVec(), 7'b0);
      applyStimulus(1, 1, 1, 0, 0);
      for (int j = 0; j < 3; j++) begin
         applyStimulus(0, 1, 1, 0, 0);
         checkOutput("heldThroughRst", dutVec(), 7'b0);
      end
      applyStimulus(0, 0, 0, 0, 0);

      $display("[TB] randomized stimulus");
      mb = 1'b0;
      ib = 1'b0;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 4) == 0) mb = ~mb;
         if ($urandom_range(0, 2) == 0) ib = ~ib;
         if ($urandom_range(0, 7) == 0) ib = 1'b1;
         applyStimulus($urandom_range(0, 99) == 0, mb, ib,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
